// File: rtl/elevator_pkg.sv
// Shared types for the elevator car controller: floor index, travel direction
// and the per-car motion state.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS_DEFAULT = 10;

    typedef logic [3:0] floor_t;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        ARRIVE,
        DOOR
    } car_state_e;

endpackage

// File: rtl/car_timer.sv
// Up-counter with synchronous clear and a terminal-count flag; the parent
// selects the terminal value per phase (floor travel or door dwell).
module car_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Per-car motion controller: moves floor by floor toward CCU targets, dwells
// with the door open, pulses `served`. Option macro: CAR_DOOR_REOPEN_EN.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS          = NUM_FLOORS_DEFAULT,
    parameter int unsigned FLOOR_TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_DWELL_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] floors_to_visit,
    input  logic                  door_obstruct,
    output logic [3:0]            current_floor,
    output logic                  direction,
    output logic                  idle,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] served
);

    localparam int unsigned MAX_CYC = (FLOOR_TRAVEL_CYCLES > DOOR_DWELL_CYCLES) ?
                                      FLOOR_TRAVEL_CYCLES : DOOR_DWELL_CYCLES;
    localparam int unsigned TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
    localparam floor_t      TOP     = floor_t'(NUM_FLOORS - 1);

    car_state_e state_q, state_d;
    floor_t     floor_q, floor_d;
    dir_t       dir_q, dir_d;
    logic       first_q, first_d;

    logic          above, below, here;
    logic          ahead, opposite;
    logic          obstruct;
    logic          timer_clr, timer_en, timer_tc;
    logic [TW-1:0] timer_term;

`ifdef CAR_DOOR_REOPEN_EN
    assign obstruct = door_obstruct;
`else
    logic unused_obstruct;
    assign unused_obstruct = door_obstruct;
    assign obstruct        = 1'b0;
`endif

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (floors_to_visit[i]) begin
                if (i > 32'(floor_q)) above = 1'b1;
                if (i < 32'(floor_q)) below = 1'b1;
                if (i == 32'(floor_q)) here = 1'b1;
            end
        end
    end

    assign ahead      = (dir_q == UP) ? above : below;
    assign opposite   = (dir_q == UP) ? below : above;
    assign timer_term = (state_q == DOOR) ? TW'(DOOR_DWELL_CYCLES - 1)
                                          : TW'(FLOOR_TRAVEL_CYCLES - 1);

    car_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .term_i (timer_term),
        .tc_o   (timer_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            floor_q <= '0;
            dir_q   <= UP;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (here) begin
                    state_d = DOOR;
                end else if (above) begin
                    dir_d   = UP;
                    state_d = MOVE;
                end else if (below) begin
                    dir_d   = DOWN;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (timer_tc) begin
                    timer_clr = 1'b1;
                    timer_en  = 1'b0;
                    state_d   = ARRIVE;
                    if (dir_q == UP && floor_q != TOP) begin
                        floor_d = floor_q + floor_t'(1);
                    end else if (dir_q == DOWN && floor_q != '0) begin
                        floor_d = floor_q - floor_t'(1);
                    end
                end
            end
            ARRIVE: begin
                if (here) begin
                    state_d = DOOR;
                end else if (ahead) begin
                    state_d = MOVE;
                end else begin
                    state_d = IDLE;
                end
            end
            DOOR: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                // An obstruction restarts the dwell and outranks a terminal count.
                if (obstruct) begin
                    timer_clr = 1'b1;
                    timer_en  = 1'b0;
                end else if (timer_tc) begin
                    timer_clr = 1'b1;
                    timer_en  = 1'b0;
                    if (ahead) begin
                        state_d = MOVE;
                    end else if (opposite) begin
                        dir_d   = (dir_q == UP) ? DOWN : UP;
                        state_d = MOVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (floor_d == '0) begin
            dir_d = UP;
        end else if (floor_d == TOP) begin
            dir_d = DOWN;
        end
        first_d = (state_d == DOOR) && (state_q != DOOR);
    end

    always_comb begin
        current_floor = floor_q;
        direction     = (dir_q == UP);
        idle          = (state_q == IDLE);
        door_open     = (state_q == DOOR);
        served        = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            served[i] = door_open && first_q && (i == 32'(floor_q));
        end
    end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: directed scenarios plus random traffic, every
// cycle compared with a countdown-based car model.
`timescale 1ns/1ps
module tb_elevator_car_ctrl;

    localparam int N  = 10;
    localparam int FT = 4;
    localparam int DW = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] ftv;
    logic         obs;
    logic [3:0]   current_floor;
    logic         direction, idle, door_open;
    logic [N-1:0] served;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    elevator_car_ctrl #(
        .NUM_FLOORS          (N),
        .FLOOR_TRAVEL_CYCLES (FT),
        .DOOR_DWELL_CYCLES   (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .floors_to_visit (ftv),
        .door_obstruct   (obs),
        .current_floor   (current_floor),
        .direction       (direction),
        .idle            (idle),
        .door_open       (door_open),
        .served          (served)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference car: a phase plus a count of cycles remaining in that phase.
    typedef enum {P_REST, P_TRAVEL, P_CHECK, P_DWELL} phase_e;
    phase_e       m_ph = P_REST;
    int           m_fl = 0, m_dr = 1, m_left = 0;
    bit           m_first = 0;
    bit           m_hi, m_lo, m_here, m_ahead, m_opp;
    logic [N-1:0] m_served;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_REST; m_fl = 0; m_dr = 1; m_left = 0; m_first = 0;
        end else begin
            m_hi = 0; m_lo = 0; m_here = 0;
            for (int i = 0; i < N; i++) begin
                if (ftv[i] && i > m_fl) m_hi = 1;
                if (ftv[i] && i < m_fl) m_lo = 1;
                if (ftv[i] && i == m_fl) m_here = 1;
            end
            m_ahead = m_dr ? m_hi : m_lo;
            m_opp   = m_dr ? m_lo : m_hi;
            m_first = 0;
            case (m_ph)
                P_REST: begin
                    if (m_here) begin m_ph = P_DWELL; m_left = DW; m_first = 1; end
                    else if (m_hi) begin m_dr = 1; m_ph = P_TRAVEL; m_left = FT; end
                    else if (m_lo) begin m_dr = 0; m_ph = P_TRAVEL; m_left = FT; end
                end
                P_TRAVEL: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_fl += m_dr ? 1 : -1;
                        m_ph = P_CHECK;
                    end
                end
                P_CHECK: begin
                    if (m_here) begin m_ph = P_DWELL; m_left = DW; m_first = 1; end
                    else if (m_ahead) begin m_ph = P_TRAVEL; m_left = FT; end
                    else m_ph = P_REST;
                end
                P_DWELL: begin
`ifdef CAR_DOOR_REOPEN_EN
                    if (obs) m_left = DW;
                    else m_left--;
`else
                    m_left--;
`endif
                    if (m_left == 0) begin
                        if (m_ahead) begin m_ph = P_TRAVEL; m_left = FT; end
                        else if (m_opp) begin m_dr = 1 - m_dr; m_ph = P_TRAVEL; m_left = FT; end
                        else m_ph = P_REST;
                    end
                end
                default: m_ph = P_REST;
            endcase
            if (m_fl == 0) m_dr = 1;
            if (m_fl == N - 1) m_dr = 0;
        end
        m_served = '0;
        if (m_ph == P_DWELL && m_first) m_served[m_fl] = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("floor", 32'(current_floor), 32'(m_fl));
            check_eq("dir", 32'(direction), 32'(m_dr));
            check_eq("idle", 32'(idle), 32'(m_ph == P_REST));
            check_eq("door", 32'(door_open), 32'(m_ph == P_DWELL));
            check_eq("served", 32'(served), 32'(m_served));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_door(input string tag);
        for (int n = 0; n < 300 && !door_open; n++) tick();
        check_eq(tag, 32'(door_open), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 300 && !idle; n++) tick();
        check_eq(tag, 32'(idle), 32'd1);
    endtask

    task automatic go_floor(input int f);
        ftv[f] = 1'b1;
        tick();
        wait_door("go_door");
        ftv[f] = 1'b0;
        wait_idle("go_idle");
        check_eq("go_floor", 32'(current_floor), 32'(f));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        bit           door_seen;
        logic         dir_at2;
        logic [N-1:0] pulses[$];
        logic [N-1:0] b2, b6, b7;
        b2 = '0; b2[2] = 1'b1;
        b6 = '0; b6[6] = 1'b1;
        b7 = '0; b7[7] = 1'b1;

        rst_n = 1'b0; ftv = '0; obs = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1;
        repeat (6) tick();
        check_eq("rst_floor", 32'(current_floor), 32'd0);
        check_eq("rst_idle", 32'(idle), 32'd1);
        check_eq("rst_dir", 32'(direction), 32'd1);
        check_eq("rst_door", 32'(door_open), 32'd0);
        check_eq("rst_served", 32'(served), 32'd0);

        // Single request to floor 3
        ftv = 10'b0000001000;
        n = 0;
        do begin tick(); n++; end while (!door_open && n < 100);
        check_eq("single_lat", 32'(n), 32'd16);
        check_eq("single_floor", 32'(current_floor), 32'd3);
        check_eq("single_served", 32'(served), 32'(10'b0000001000));
        ftv = '0;
        tick();
        check_eq("single_served_end", 32'(served), 32'd0);
        wait_idle("single_idle");

        // Door dwell with an obstruction pulse in dwell cycle 2
        ftv[3] = 1'b1;
        tick();
        ftv = '0;
        n = 0;
        while (door_open && n < 50) begin
            n++;
            obs = (n == 2);
            tick();
        end
        obs = 1'b0;
`ifdef CAR_DOOR_REOPEN_EN
        check_eq("reopen_len", 32'(n), 32'd5);
`else
        check_eq("reopen_len", 32'(n), 32'd3);
`endif
        wait_idle("reopen_idle");

        // Reversal: door open at 5 going up, targets 7 and 2
        ftv[5] = 1'b1;
        tick();
        wait_door("rev_door5");
        check_eq("rev_dir5", 32'(direction), 32'd1);
        ftv = b7 | b2;
        dir_at2 = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (served != '0) begin
                pulses.push_back(served);
                if (served == b2) dir_at2 = direction;
                ftv &= ~served;
            end
            if (idle) break;
        end
        check_eq("rev_count", 32'(pulses.size()), 32'd2);
        check_eq("rev_first", 32'(pulses[0]), 32'(b7));
        check_eq("rev_second", 32'(pulses[1]), 32'(b2));
        check_eq("rev_dir2", 32'(dir_at2), 32'd0);
        wait_idle("rev_idle");

        // Withdrawn target: floor 2 -> 4, removed during first transit
        ftv[4] = 1'b1;
        tick(); tick();
        ftv = '0;
        door_seen = 0;
        for (int k = 0; k < 100 && !idle; k++) begin
            tick();
            if (door_open) door_seen = 1;
        end
        check_eq("wd_idle", 32'(idle), 32'd1);
        check_eq("wd_floor", 32'(current_floor), 32'd3);
        check_eq("wd_nodoor", 32'(door_seen), 32'd0);

        // Here request at floor 6
        go_floor(6);
        ftv = b6;
        tick();
        check_eq("here_door", 32'(door_open), 32'd1);
        check_eq("here_served", 32'(served), 32'(b6));
        check_eq("here_floor", 32'(current_floor), 32'd6);
        ftv = '0;
        wait_idle("here_idle");

        // Random traffic; upstream latches clear on served, occasional reset
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 11) == 0) ftv[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 59) == 0) ftv[$urandom_range(0, N - 1)] = 1'b0;
            obs = ($urandom_range(0, 7) == 0);
            if (m_served != '0) ftv &= ~m_served;
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
            end
            tick();
        end
        obs = 1'b0;
        ftv = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
